// File: rtl/rv_mem_pkg.sv
// +----------------------------------------------------------------------+
// | rv_mem_pkg: shared encodings for the multicycle memory access path    |
// | rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

package rv_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    LOAD  = 2'd1,
    STORE = 2'd2
  } kind_t;

endpackage

`default_nettype wire

// File: rtl/ls_align.sv
// +----------------------------------------------------------------------+
// | ls_align: byte-lane alignment for stores, extension for loads         |
// | rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module ls_align import rv_mem_pkg::*; (
  input  logic [2:0]  func3,
  input  logic [1:0]  addr_lo,
  input  logic        is_store,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  output logic [31:0] load_val,
  output logic        legal
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr_lo)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    wstrb    = 4'b0000;
    wdata    = store_data;
    load_val = rdata;
    legal    = 1'b0;
    case (func3)
      F3_B: begin
        legal    = 1'b1;
        wstrb    = 4'b0001 << addr_lo;
        wdata    = {4{store_data[7:0]}};
        load_val = {{24{byte_sel[7]}}, byte_sel};
      end
      F3_H: begin
        legal    = ~addr_lo[0];
        wstrb    = 4'b0011 << addr_lo;
        wdata    = {2{store_data[15:0]}};
        load_val = {{16{half_sel[15]}}, half_sel};
      end
      F3_W: begin
        legal    = (addr_lo == 2'b00);
        wstrb    = 4'b1111;
      end
      // Unsigned forms exist only for loads.
      F3_BU: begin
        legal    = ~is_store;
        load_val = {24'b0, byte_sel};
      end
      F3_HU: begin
        legal    = ~is_store & ~addr_lo[0];
        load_val = {16'b0, half_sel};
      end
      default: legal = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_access_unit.sv
// +----------------------------------------------------------------------+
// | mem_access_unit: turns control strobes into one req/ack bus access    |
// | rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module mem_access_unit import rv_mem_pkg::*; #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              IRWrite,
  input  logic              IorD,
  input  logic              MemoryWrite,
  input  logic [2:0]        func3,
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] store_data,
  output logic              busy,
  output logic              done,
  output logic              fault,
  output logic              bus_err,
  output logic [DATA_W-1:0] instr,
  output logic [DATA_W-1:0] mdr,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_wstrb,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int              CNT_W   = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

  state_t            state_q, state_d;
  kind_t             kind_q, kind_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        func3_q, func3_d;
  logic [DATA_W-1:0] sdata_q, sdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              done_q, done_d;
  logic              fault_q, fault_d;
  logic              bus_err_q, bus_err_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [DATA_W-1:0] mdr_q, mdr_d;

  logic              idle, trigger, req_legal;
  kind_t             req_kind;
  logic [ADDR_W-1:0] req_addr;
  logic [2:0]        la_func3;
  logic [1:0]        la_lo;
  logic              la_store, la_legal;
  logic [3:0]        la_wstrb;
  logic [31:0]       la_wdata, la_load_val;

  assign idle     = (state_q == IDLE);
  assign trigger  = IorD | IRWrite;
  assign req_kind = IorD ? (MemoryWrite ? STORE : LOAD) : FETCH;
  assign req_addr = IorD ? alu_addr : pc;

  // In IDLE the aligner judges the incoming request; afterwards it serves the latched one.
  assign la_func3 = idle ? func3 : func3_q;
  assign la_lo    = idle ? req_addr[1:0] : addr_q[1:0];
  assign la_store = idle ? (req_kind == STORE) : (kind_q == STORE);

  ls_align u_align (
    .func3      (la_func3),
    .addr_lo    (la_lo),
    .is_store   (la_store),
    .store_data (sdata_q),
    .rdata      (mem_rdata),
    .wstrb      (la_wstrb),
    .wdata      (la_wdata),
    .load_val   (la_load_val),
    .legal      (la_legal)
  );

  assign req_legal = (req_kind == FETCH) ? (pc[1:0] == 2'b00) : la_legal;

  always_comb begin
    state_d   = state_q;
    kind_d    = kind_q;
    addr_d    = addr_q;
    func3_d   = func3_q;
    sdata_d   = sdata_q;
    cnt_d     = cnt_q;
    instr_d   = instr_q;
    mdr_d     = mdr_q;
    done_d    = 1'b0;
    fault_d   = 1'b0;
    bus_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (trigger) begin
          kind_d  = req_kind;
          addr_d  = req_addr;
          func3_d = func3;
          sdata_d = store_data;
          cnt_d   = '0;
          if (req_legal) begin
            state_d = REQ;
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
            fault_d = 1'b1;
          end
        end
      end
      REQ: begin
        // Ack is tested first so an ack on the last allowed cycle still succeeds.
        if (mem_ack) begin
          state_d = DONE;
          done_d  = 1'b1;
          cnt_d   = '0;
          if (kind_q == FETCH) instr_d = mem_rdata;
          else if (kind_q == LOAD) mdr_d = la_load_val;
        end else if (cnt_q == CNT_MAX) begin
          state_d   = DONE;
          done_d    = 1'b1;
          bus_err_d = 1'b1;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q   <= IDLE;
      kind_q    <= FETCH;
      addr_q    <= '0;
      func3_q   <= '0;
      sdata_q   <= '0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      fault_q   <= 1'b0;
      bus_err_q <= 1'b0;
      instr_q   <= '0;
      mdr_q     <= '0;
    end else begin
      state_q   <= state_d;
      kind_q    <= kind_d;
      addr_q    <= addr_d;
      func3_q   <= func3_d;
      sdata_q   <= sdata_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      fault_q   <= fault_d;
      bus_err_q <= bus_err_d;
      instr_q   <= instr_d;
      mdr_q     <= mdr_d;
    end
  end

  assign busy      = ~idle;
  assign done      = done_q;
  assign fault     = fault_q;
  assign bus_err   = bus_err_q;
  assign instr     = instr_q;
  assign mdr       = mdr_q;
  assign mem_req   = (state_q == REQ);
  assign mem_we    = mem_req & (kind_q == STORE);
  assign mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
  assign mem_wstrb = mem_we ? la_wstrb : 4'b0000;
  assign mem_wdata = mem_we ? la_wdata : '0;

endmodule

`default_nettype wire

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Multicycle memory-port sequencer that sits directly downstream of the control FSM. It turns the control strobes IRWrite, IorD and MemoryWrite into one req/ack bus transaction. The block aligns store data into byte lanes and sign- or zero-extends load data. It holds the fetched instruction (instr) and the memory data register (mdr), and reports busy/done/fault so the control FSM can stall.

Parameters:
ADDR_W, 32, byte-address width
DATA_W, 32, bus data width (fixed at 32; byte lanes = 4)
TIMEOUT, 16, maximum REQ cycles waiting for mem_ack before bus error (must be >= 2)

Ports:
clk  in  1  clock, rising edge
clr_n  in  1  asynchronous active-low reset
IRWrite  in  1  fetch request from control (used when IorD=0)
IorD  in  1  1 = data access at alu_addr, 0 = fetch at pc
MemoryWrite  in  1  with IorD=1: store, else load
func3  in  3  load/store size/sign code
pc  in  ADDR_W  fetch address
alu_addr  in  ADDR_W  data address
store_data  in  32  rs2 value for stores
busy  out  1  access in progress (REQ or DONE)
done  out  1  one-cycle completion pulse
fault  out  1  with done: misaligned/illegal func3 (no bus cycle issued)
bus_err  out  1  with done: timeout
instr  out  32  last fetched instruction
mdr  out  32  last extended load value
mem_req  out  1  bus request, held until ack or timeout
mem_we  out  1  write enable
mem_addr  out  ADDR_W  word-aligned address {addr[ADDR_W-1:2],2'b00}
mem_wstrb  out  4  byte-lane strobes
mem_wdata  out  32  lane-replicated store data
mem_ack  in  1  bus accept; for reads, mem_rdata is valid in the same cycle
mem_rdata  in  32  read data

Behaviour:
- Reset (async, clr_n=0): state IDLE; timeout counter 0; all outputs 0, including instr and mdr; mem_req drops immediately even mid-transaction.
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - Trigger = IorD | IRWrite; a trigger in cycle N latches the request (kind, address, func3, store_data).
  - Legal request -> REQ at N+1.
  - Illegal request -> DONE at N+1 with fault=1; no bus cycle is issued.
- Legality:
  - Fetch requires pc[1:0]=00.
  - Load func3 must be 000/001/010/100/101; store func3 must be 000/001/010.
  - Halfword requires addr[0]=0; word requires addr[1:0]=00.
  - Any other combination is illegal.
- REQ:
  - mem_req=1; mem_addr, mem_we, mem_wstrb, mem_wdata are stable until the state is left.
  - mem_ack=1 -> DONE next cycle; read data is captured into instr (fetch) or mdr (load) on that edge.
  - Otherwise the counter increments. If it reaches TIMEOUT-1 with no ack -> DONE with bus_err=1; instr and mdr are unchanged.
  - Ack in the same cycle as the timeout: ack wins.
- DONE: done=1 for exactly one cycle -> IDLE. Earliest done for a legal access = N+2 (ack in the first REQ cycle).
- Requests arriving while busy=1 are ignored. Control must deassert its strobes the cycle after done, otherwise a new access starts.
- Store lanes, with a = addr[1:0]:
  - SB: wstrb = 1<<a; wdata = {4{b}}.
  - SH: wstrb = 0011<<a; wdata = {2{h}}.
  - SW: wstrb = 1111.
- Loads:
  - Read strobes = 0000.
  - Select byte/half at lane a.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW is passed through.
- Priority: IorD overrides IRWrite when both are high.
- fault and bus_err are 0 whenever done=0.
- busy = (state != IDLE).

Decomposition:
- Package rv_mem_pkg holds:
  - func3 constants F3_B/H/W/BU/HU.
  - Load/store opcode constants 7'b0000011 / 7'b0100011.
  - State encoding IDLE/REQ/DONE.
  - Request-kind encoding FETCH/LOAD/STORE.
- One combinational sub-module, ls_align: func3 + addr[1:0] + store_data + mem_rdata -> wstrb, wdata, extended load value, legal flag.
- The FSM, counter and registers live in mem_access_unit.

Test Plan:
- Fetch: IRWrite=1, pc=0x100, ack on the first REQ cycle with rdata=0x00A00093 -> mem_addr=0x100, mem_we=0, done at N+2, instr=0x00A00093, fault=0.
- Store byte: IorD=1, MemoryWrite=1, func3=000, alu_addr=0x203, store_data=0x12345678 -> wstrb=1000, wdata=0x78787878, mem_addr=0x200, mem_we=1.
- Loads at addr 0x2, rdata=0x80FF0000: LH -> mdr=0xFFFF80FF; LHU -> mdr=0x000080FF. LB at addr 0x3 with the same rdata -> mdr=0xFFFFFF80.
- Misaligned: LW at 0x106 -> mem_req never asserted; done and fault pulse together at N+1; mdr unchanged.
- Timeout: TIMEOUT=4, ack held low -> mem_req high 4 cycles, then done+bus_err. Repeat with ack on the 4th REQ cycle -> normal done, bus_err=0.
- Reset mid-REQ: clr_n low while mem_req=1 -> mem_req, busy, instr and mdr go to 0 without a clock edge; the next request after release proceeds normally.
